// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single-precision add/subtract sequencer.
// Unpacks both operands, orders them so the larger magnitude is A, aligns B,
// routes B through an external combinational two's-complement unit when the
// operation is an effective subtraction, adds, normalises one bit per cycle
// and packs a truncated result. Denormal inputs are flushed to zero.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   sub          1 = A - B, 0 = A + B
//   op_a, op_b   IEEE single operands
//   busy         high while an operation is in flight (ALIGN..DONE)
//   done         one-cycle pulse, result valid
//   result       registered result, held until overwritten
//   comp_en      complement select to the shared unit (COMP state only)
//   comp_operand operand to the shared unit (COMP state only)
//   comp_result  same-cycle output of the shared unit
module fp_addsub_seq #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sub,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              comp_en,
    output logic [MANT_W-1:0] comp_operand,
    input  logic [MANT_W-1:0] comp_result
);
    localparam int FRAC_W = MANT_W - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_COMP, S_ADD, S_NORM, S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        a_reg, a_next, b_reg, b_next;
    logic               sub_reg, sub_next;
    logic               sign_reg, sign_next;
    logic               eff_sub_reg, eff_sub_next;
    logic [EXP_W-1:0]   exp_reg, exp_next;
    logic [MANT_W-1:0]  mant_a_reg, mant_a_next;   // larger significand / working mantissa
    logic [MANT_W-1:0]  mant_b_reg, mant_b_next;   // aligned (and maybe complemented) smaller
    logic [31:0]        result_reg, result_next;

    // Unpacked view of the captured operands
    logic [EXP_W-1:0]   exp_ua, exp_ub, exp_l, exp_s, diff;
    logic [MANT_W-1:0]  mant_ua, mant_ub, mant_l, mant_s, mant_s_al;
    logic               sign_ua, sign_ub, swap, special;

    assign exp_ua  = a_reg[30:23];
    assign exp_ub  = b_reg[30:23];
    assign mant_ua = (exp_ua == '0) ? '0 : {1'b1, a_reg[22:0]};
    assign mant_ub = (exp_ub == '0) ? '0 : {1'b1, b_reg[22:0]};
    assign sign_ua = a_reg[31];
    assign sign_ub = b_reg[31] ^ sub_reg;
    assign special = (exp_ua == '1) || (exp_ub == '1);
    assign swap    = {exp_ub, mant_ub} > {exp_ua, mant_ua};
    assign exp_l   = swap ? exp_ub : exp_ua;
    assign exp_s   = swap ? exp_ua : exp_ub;
    assign mant_l  = swap ? mant_ub : mant_ua;
    assign mant_s  = swap ? mant_ua : mant_ub;
    assign diff    = exp_l - exp_s;
    // Shifting by the full width or more leaves nothing; shifted-out bits are dropped.
    assign mant_s_al = (diff >= EXP_W'(MANT_W)) ? '0 : (mant_s >> diff);

    logic [MANT_W:0]    sum;
    logic [EXP_W-1:0]   exp_inc, exp_dec;
    logic [MANT_W-1:0]  mant_shl;

    assign sum      = {1'b0, mant_a_reg} + {1'b0, mant_b_reg};
    assign exp_inc  = exp_reg + 1'b1;
    assign exp_dec  = exp_reg - 1'b1;
    assign mant_shl = {mant_a_reg[MANT_W-2:0], 1'b0};

    assign busy   = (state_reg != S_IDLE);
    assign done   = (state_reg == S_DONE);
    assign result = result_reg;

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        sub_next     = sub_reg;
        sign_next    = sign_reg;
        eff_sub_next = eff_sub_reg;
        exp_next     = exp_reg;
        mant_a_next  = mant_a_reg;
        mant_b_next  = mant_b_reg;
        result_next  = result_reg;
        comp_en      = 1'b0;
        comp_operand = '0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    a_next     = op_a;
                    b_next     = op_b;
                    sub_next   = sub;
                    state_next = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (special) begin
                    // Any Inf/NaN operand yields infinity carrying A's sign.
                    result_next = {sign_ua, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    state_next  = S_DONE;
                end else begin
                    sign_next    = swap ? sign_ub : sign_ua;
                    eff_sub_next = (sign_ua != sign_ub);
                    exp_next     = exp_l;
                    mant_a_next  = mant_l;
                    mant_b_next  = mant_s_al;
                    state_next   = S_COMP;
                end
            end
            S_COMP: begin
                comp_en      = eff_sub_reg;
                comp_operand = mant_b_reg;
                if (eff_sub_reg)
                    mant_b_next = comp_result;
                state_next = S_ADD;
            end
            S_ADD: begin
                if (!eff_sub_reg && sum[MANT_W]) begin
                    // Carry out: renormalise right by one; may overflow to infinity.
                    if (exp_inc == '1)
                        result_next = {sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    else
                        result_next = {sign_reg, exp_inc, sum[MANT_W-1:1]};
                    state_next = S_DONE;
                end else if (sum[MANT_W-1:0] == '0) begin
                    // Exact cancellation gives +0; adding two zeros keeps the sign.
                    result_next = eff_sub_reg ? 32'h0 : {sign_reg, 31'h0};
                    state_next  = S_DONE;
                end else if (sum[MANT_W-1]) begin
                    result_next = {sign_reg, exp_reg, sum[FRAC_W-1:0]};
                    state_next  = S_DONE;
                end else begin
                    mant_a_next = sum[MANT_W-1:0];
                    state_next  = S_NORM;
                end
            end
            S_NORM: begin
                exp_next    = exp_dec;
                mant_a_next = mant_shl;
                if (exp_dec == '0) begin
                    result_next = {sign_reg, 31'h0};   // underflow flushes to signed zero
                    state_next  = S_DONE;
                end else if (mant_shl[MANT_W-1]) begin
                    result_next = {sign_reg, exp_dec, mant_shl[FRAC_W-1:0]};
                    state_next  = S_DONE;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sub_reg     <= 1'b0;
            sign_reg    <= 1'b0;
            eff_sub_reg <= 1'b0;
            exp_reg     <= '0;
            mant_a_reg  <= '0;
            mant_b_reg  <= '0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            sub_reg     <= sub_next;
            sign_reg    <= sign_next;
            eff_sub_reg <= eff_sub_next;
            exp_reg     <= exp_next;
            mant_a_reg  <= mant_a_next;
            mant_b_reg  <= mant_b_next;
            result_reg  <= result_next;
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Testbench for fp_addsub_seq: directed vectors with hand-computed results,
// latencies and complement-unit traffic; a scoreboard queue is filled at
// issue time and drained by a monitor on every done pulse.
module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done, comp_en;
    logic [31:0] result;
    logic [23:0] comp_operand, comp_result;

    // Behavioural stand-in for the shared two's-complement unit.
    assign comp_result = comp_en ? (~comp_operand + 24'd1) : comp_operand;

    fp_addsub_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
        .comp_en(comp_en), .comp_operand(comp_operand), .comp_result(comp_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        bit          cen;
        logic [23:0] cop;
        int          issue;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   txn = 0;
    bit          comp_seen = 1'b0;
    logic [23:0] comp_op_seen = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Monitor: records complement-unit traffic, checks each done against the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            comp_seen    = 1'b0;
            comp_op_seen = '0;
        end else begin
            if (comp_en) begin
                comp_seen    = 1'b1;
                comp_op_seen = comp_operand;
            end
            if (done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", {31'h0, done}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    txn++;
                    $display("txn %0d: result %h (expect %h) latency %0d (expect %0d) comp_en %0d operand %h",
                             txn, result, e.res, cyc - e.issue, e.lat, comp_seen, comp_op_seen);
                    chk("result", result, e.res);
                    chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                    chk("comp_en_seen", {31'h0, comp_seen}, {31'h0, e.cen});
                    chk("comp_operand", {8'h0, comp_op_seen}, {8'h0, e.cop});
                end
                comp_seen    = 1'b0;
                comp_op_seen = '0;
            end
        end
    end

    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input bit push, input logic [31:0] res, input int lat,
                               input bit cen, input logic [23:0] cop);
        exp_t e;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        if (push) begin
            e.res = res; e.lat = lat; e.cen = cen; e.cop = cop; e.issue = cyc;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;   // operands must have been captured at accept
        op_b  = $urandom;
        sub   = ~s;
    endtask

    task automatic wait_done();
        int base;
        bit seen;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'h0, 32'h1);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] res, input int lat, input bit cen, input logic [23:0] cop);
        drive_start(a, b, s, 1'b1, res, lat, cen, cop);
        wait_done();
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_comp_en", {31'h0, comp_en}, 32'h0);
        chk("rst_comp_operand", {8'h0, comp_operand}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4, 1'b0, 24'h0);
        // 1.5 - 1.0 with a start pulse while busy that must be ignored
        drive_start(32'h3FC00000, 32'h3F800000, 1'b1, 1'b1, 32'h3F000000, 5, 1'b1, 24'h800000);
        op_a  = 32'h40400000;
        op_b  = 32'h40400000;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (8) @(negedge clk);   // a spurious second done would be flagged by the monitor

        run(32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 5, 1'b1, 24'h800000);
        run(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4, 1'b1, 24'h800000);
        run(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4, 1'b0, 24'h0);
        run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4, 1'b0, 24'h0);
        run(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4, 1'b1, 24'h400000);
        run(32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 4, 1'b0, 24'h0);
        run(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 2, 1'b0, 24'h0);
        run(32'h3F800000, 32'h7F800000, 1'b1, 32'h7F800000, 2, 1'b0, 24'h0);
        run(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 5, 1'b1, 24'h800000);
        run(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 27, 1'b1, 24'h800000);

        // Reset in the middle of a long normalisation
        drive_start(32'h3F800001, 32'h3F800000, 1'b1, 1'b0, 32'h0, 0, 1'b0, 24'h0);
        repeat (6) @(negedge clk);
        chk("mid_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_result", result, 32'h0);
        chk("abort_comp_en", {31'h0, comp_en}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (35) @(negedge clk);
        #1;
        chk("abort_no_done_result", result, 32'h0);

        // Recovery after the abort
        run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4, 1'b0, 24'h0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
